eth_rx_deframer: RTL and testbench

//  Front end of the receive path. Takes the raw GMII-style byte stream from the PHY and strips
//  the preamble and SFD. It then re-times the frame (DA..FCS) into the udp_rx/valid/first/last

---
 rtl/eth_pkg.sv | 15 +
 rtl/eth_sat_counter.sv | 19 +
 rtl/eth_rx_deframer.sv | 145 ++++++++++++++
 tb/tb_eth_rx_deframer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet receive front end.
package eth_pkg;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD           = 8'hD5;
    localparam int         ETH_STATE_W       = 3;

    typedef enum logic [ETH_STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_DROP     = 3'd3
    } eth_rx_state_t;

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating up-counter; sticks at all-ones.
module eth_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/eth_rx_deframer.sv
// Strips preamble/SFD from the GMII receive stream and re-times DA..FCS into the
// udp_rx first/last stream through a one-byte hold register, flagging bad frames.
//
// state       | meaning
// ST_IDLE     | waiting for dv with a preamble byte
// ST_PREAMBLE | counting 0x55 bytes, waiting for SFD
// ST_DATA     | frame body; hold register delays each byte by one clock
// ST_DROP     | discarding the rest of a burst until dv falls
module eth_rx_deframer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_MIN  = 2,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  udp_rx,
    output logic        udp_rx_valid,
    output logic        udp_rx_first,
    output logic        udp_rx_last,
    output logic        frame_abort,
    output logic [15:0] good_frames,
    output logic [15:0] bad_frames
);

    localparam logic [2:0]  PRE_MIN = 3'(PREAMBLE_MIN);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    eth_rx_state_t state;
    logic [2:0]    pcnt;
    logic [15:0]   len;
    logic [7:0]    hold;
    logic          hold_first;
    logic          hold_vld;
    logic          good_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            pcnt         <= '0;
            len          <= '0;
            hold         <= '0;
            hold_first   <= 1'b0;
            hold_vld     <= 1'b0;
            good_end     <= 1'b0;
            udp_rx       <= '0;
            udp_rx_valid <= 1'b0;
            udp_rx_first <= 1'b0;
            udp_rx_last  <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            udp_rx_valid <= 1'b0;
            udp_rx_first <= 1'b0;
            udp_rx_last  <= 1'b0;
            frame_abort  <= 1'b0;
            good_end     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == ETH_PREAMBLE_BYTE) begin
                            state <= ST_PREAMBLE;
                            pcnt  <= 3'd1;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state <= ST_IDLE;
                    end else if (gmii_rx_er) begin
                        state <= ST_DROP;
                    end else if (gmii_rxd == ETH_PREAMBLE_BYTE) begin
                        if (pcnt != 3'd7) pcnt <= pcnt + 3'd1;
                    end else if ((gmii_rxd == ETH_SFD) && (pcnt >= PRE_MIN)) begin
                        state    <= ST_DATA;
                        len      <= '0;
                        hold_vld <= 1'b0;
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!gmii_rx_dv) begin
                        // Normal end: flush the held byte as last; short or empty frames abort.
                        if (hold_vld) begin
                            udp_rx       <= hold;
                            udp_rx_valid <= 1'b1;
                            udp_rx_first <= hold_first;
                            udp_rx_last  <= 1'b1;
                        end
                        if (len < MIN_LEN) frame_abort <= 1'b1;
                        else               good_end    <= 1'b1;
                        hold_vld <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (gmii_rx_er || (len >= MAX_LEN)) begin
                        if (hold_vld) begin
                            udp_rx       <= hold;
                            udp_rx_valid <= 1'b1;
                            udp_rx_first <= hold_first;
                            udp_rx_last  <= 1'b1;
                        end
                        frame_abort <= 1'b1;
                        hold_vld    <= 1'b0;
                        state       <= ST_DROP;
                    end else begin
                        if (hold_vld) begin
                            udp_rx       <= hold;
                            udp_rx_valid <= 1'b1;
                            udp_rx_first <= hold_first;
                        end
                        hold       <= gmii_rxd;
                        hold_first <= (len == 16'd0);
                        hold_vld   <= 1'b1;
                        len        <= len + 16'd1;
                    end
                end
                ST_DROP: begin
                    if (!gmii_rx_dv) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    eth_sat_counter #(.WIDTH(16)) u_good_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (good_end),
        .count (good_frames)
    );

    eth_sat_counter #(.WIDTH(16)) u_bad_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_abort),
        .count (bad_frames)
    );

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Randomized + directed bench for eth_rx_deframer against a burst-level frame parser model.
module tb_eth_rx_deframer;

    localparam int PRE_MIN = 2;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  udp_rx;
    logic        udp_rx_valid, udp_rx_first, udp_rx_last, frame_abort;
    logic [15:0] good_frames, bad_frames;

    eth_rx_deframer #(
        .PREAMBLE_MIN  (PRE_MIN),
        .MIN_FRAME_LEN (MIN_LEN),
        .MAX_FRAME_LEN (MAX_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gmii_rxd     (gmii_rxd),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .udp_rx       (udp_rx),
        .udp_rx_valid (udp_rx_valid),
        .udp_rx_first (udp_rx_first),
        .udp_rx_last  (udp_rx_last),
        .frame_abort  (frame_abort),
        .good_frames  (good_frames),
        .bad_frames   (bad_frames)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bit         st_dv[$];
    bit         st_er[$];
    logic [7:0] st_d[$];

    bit         ev_v[$], ev_f[$], ev_l[$], ev_a[$];
    logic [7:0] ev_d[$];
    logic [11:0] exp_w[$];
    int exp_good, exp_bad;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit dv, input bit er, input logic [7:0] d);
        st_dv.push_back(dv);
        st_er.push_back(er);
        st_d.push_back(d);
    endtask

    task automatic add_gap(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    endtask

    task automatic add_frame(input int npre, input int pre_er, input logic [7:0] sfd,
                             input int len, input int er_at, input bit ramp);
        for (int i = 0; i < npre; i++) push(1'b1, i == pre_er, 8'h55);
        push(1'b1, 1'b0, sfd);
        for (int i = 0; i < len; i++)
            push(1'b1, i == er_at, ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    // One dv burst [a, b) always starts from idle; b is the first dv-low cycle.
    task automatic decode_run(input int a, input int b);
        int j, d, q, len_f;
        bit clean;
        if (st_d[a] != 8'h55) return;
        j = 1;
        while ((a + j) < b && !st_er[a + j] && st_d[a + j] == 8'h55) j++;
        if ((a + j) == b) return;
        if (st_er[a + j] || st_d[a + j] != 8'hD5 || ((j > 7) ? 7 : j) < PRE_MIN) return;
        d = a + j + 1;
        q = d;
        while (q < b && !st_er[q] && (q - d) < MAX_LEN) q++;
        len_f = q - d;
        clean = (q == b);
        for (int i = 0; i < len_f; i++) begin
            ev_v[d + i + 1] = 1'b1;
            ev_d[d + i + 1] = st_d[d + i];
            ev_f[d + i + 1] = (i == 0);
            ev_l[d + i + 1] = (i == len_f - 1);
        end
        if (!clean || len_f < MIN_LEN) begin
            ev_a[q] = 1'b1;
            exp_bad++;
        end else begin
            exp_good++;
        end
    endtask

    task automatic build_model();
        int n, a, b;
        logic [7:0] held;
        n = st_dv.size();
        ev_v.delete(); ev_f.delete(); ev_l.delete(); ev_a.delete(); ev_d.delete(); exp_w.delete();
        for (int c = 0; c < n; c++) begin
            ev_v.push_back(1'b0); ev_f.push_back(1'b0); ev_l.push_back(1'b0);
            ev_a.push_back(1'b0); ev_d.push_back(8'h00);
        end
        exp_good = 0;
        exp_bad  = 0;
        a = 0;
        while (a < n) begin
            if (!st_dv[a]) begin
                a++;
            end else begin
                b = a;
                while (b < n && st_dv[b]) b++;
                decode_run(a, b);
                a = b;
            end
        end
        held = 8'h00;
        for (int c = 0; c < n; c++) begin
            if (ev_v[c]) held = ev_d[c];
            exp_w.push_back({ev_v[c], ev_f[c], ev_l[c], ev_a[c], held});
        end
    endtask

    task automatic play(input int upto);
        for (int c = 0; c < upto; c++) begin
            gmii_rx_dv = st_dv[c];
            gmii_rx_er = st_er[c];
            gmii_rxd   = st_d[c];
            @(posedge clk);
            #1;
            chk_val($sformatf("beat%0d", c),
                    {20'd0, udp_rx_valid, udp_rx_first, udp_rx_last, frame_abort, udp_rx},
                    {20'd0, exp_w[c]});
        end
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
    endtask

    task automatic run_phase(input string tag);
        add_gap(3);
        build_model();
        play(st_dv.size());
        chk_val({tag, "_good"}, {16'd0, good_frames}, 32'(exp_good));
        chk_val({tag, "_bad"},  {16'd0, bad_frames},  32'(exp_bad));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_out", {20'd0, udp_rx_valid, udp_rx_first, udp_rx_last, frame_abort, udp_rx}, 32'd0);
        chk_val("rst_cnt", {good_frames, bad_frames}, 32'd0);
        rst = 1'b0;
        st_dv.delete(); st_er.delete(); st_d.delete();
    endtask

    initial begin
        int npre, pre_er, len, er_at, sel, mid;
        logic [7:0] sfd;

        // 1: nominal 64-byte frame
        do_reset();
        add_frame(7, -1, 8'hD5, 64, -1, 1'b1);
        run_phase("t1");
        chk_val("t1_good_exact", {16'd0, good_frames}, 32'd1);

        // 2: one-byte runt
        do_reset();
        add_frame(2, -1, 8'hD5, 1, -1, 1'b0);
        run_phase("t2");
        chk_val("t2_bad_exact", {16'd0, bad_frames}, 32'd1);

        // 3: rx_er on the sixth data byte
        do_reset();
        add_frame(7, -1, 8'hD5, 10, 5, 1'b1);
        run_phase("t3");

        // 4: preamble too short, then a good frame after a one-cycle gap
        do_reset();
        add_frame(1, -1, 8'hD5, 64, -1, 1'b0);
        push(1'b0, 1'b0, 8'h00);
        add_frame(7, -1, 8'hD5, 64, -1, 1'b1);
        run_phase("t4");

        // 5: overlength frame
        do_reset();
        add_frame(7, -1, 8'hD5, 1600, -1, 1'b0);
        run_phase("t5");
        chk_val("t5_bad_exact", {16'd0, bad_frames}, 32'd1);

        // random mix of preamble, SFD, length and error placements
        do_reset();
        for (int f = 0; f < 50; f++) begin
            npre   = $urandom_range(0, 8);
            pre_er = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 7) : -1;
            sfd    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'hD5;
            sel    = $urandom_range(0, 19);
            if (sel < 3)       len = $urandom_range(0, 3);
            else if (sel < 8)  len = $urandom_range(62, 66);
            else if (sel == 19) len = $urandom_range(1520, 1524);
            else               len = $urandom_range(4, 150);
            er_at = ($urandom_range(0, 5) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
            add_frame(npre, pre_er, sfd, len, er_at, 1'b0);
            add_gap($urandom_range(1, 3));
        end
        run_phase("rnd");

        // 6: asynchronous reset in the middle of a frame body
        do_reset();
        add_frame(7, -1, 8'hD5, 64, -1, 1'b1);
        push(1'b0, 1'b0, 8'h00);
        mid = st_dv.size() + 8 + 20;
        add_frame(7, -1, 8'hD5, 64, -1, 1'b1);
        add_gap(3);
        build_model();
        play(mid);
        #2 rst = 1'b1;
        #1;
        chk_val("t6_async_out", {20'd0, udp_rx_valid, udp_rx_first, udp_rx_last, frame_abort, udp_rx}, 32'd0);
        chk_val("t6_async_cnt", {good_frames, bad_frames}, 32'd0);
        do_reset();
        add_frame(7, -1, 8'hD5, 64, -1, 1'b1);
        run_phase("t6");
        chk_val("t6_good_exact", {16'd0, good_frames}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
